trap_seq: RTL

//  Multi-cycle trap/return sequencer between EXU and the CSR file.

---
 rtl/trap_pkg.sv | 29 ++
 rtl/trap_seq.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/trap_pkg.sv
// Shared constants for the trap/return sequencer: CSR addresses, cause codes,
// mstatus field positions and the sequencer state encoding.
package trap_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
    localparam logic [3:0] CAUSE_BREAK   = 4'd3;
    localparam logic [3:0] CAUSE_ECALL_M = 4'd11;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_HI = 12;
    localparam int MSTATUS_MPP_LO = 11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_W_EPC     = 3'd1,
        ST_W_CAUSE   = 3'd2,
        ST_W_STAT    = 3'd3,
        ST_REDIR     = 3'd4,
        ST_R_STAT    = 3'd5,
        ST_REDIR_RET = 3'd6
    } state_t;

endpackage

// File: rtl/trap_seq.sv
// Trap/return sequencer: turns EXU ecall/ebreak/illegal/mret events into a
// fixed series of CSR writes through the single write port, then redirects the IFU.
//
// state        | meaning
// IDLE         | ready for an EXU event
// W_EPC        | write mepc with the word-aligned faulting PC
// W_CAUSE      | write mcause
// W_STAT       | read-modify-write mstatus on trap entry
// REDIR        | redirect to mtvec (base only), hold until accepted
// R_STAT       | read-modify-write mstatus on mret
// REDIR_RET    | redirect to mepc, hold until accepted
module trap_seq
    import trap_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter bit ILLEGAL_EN = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_ex_valid,
    output logic            o_ex_ready,
    input  logic            i_ex_ecall,
    input  logic            i_ex_ebreak,
    input  logic            i_ex_illegal,
    input  logic            i_ex_mret,
    input  logic [XLEN-1:0] i_ex_pc,
    output logic            o_busy,
    output logic            o_csr_wr_en,
    output logic            o_csr_wr_set,
    output logic [11:0]     o_csr_wr_reg,
    output logic [XLEN-1:0] o_csr_wr_bus,
    output logic [11:0]     o_csr_rd_reg,
    input  logic [XLEN-1:0] i_csr_rd_bus,
    output logic            o_redir_valid,
    input  logic            i_redir_ready,
    output logic [XLEN-1:0] o_redir_pc
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_pc_q;
    logic [3:0]      r_cause_q;
    logic            w_illegal;
    logic            w_trap;
    logic            w_accept;
    logic [3:0]      w_cause;

    // Highest-priority flag wins; the rest of the event is dropped.
    always_comb begin
        w_illegal = (ILLEGAL_EN != 1'b0) && i_ex_illegal;
        w_trap    = w_illegal || i_ex_ebreak || i_ex_ecall;
        if (w_illegal) begin
            w_cause = CAUSE_ILLEGAL;
        end else if (i_ex_ebreak) begin
            w_cause = CAUSE_BREAK;
        end else begin
            w_cause = CAUSE_ECALL_M;
        end
    end

    assign w_accept     = i_ex_valid && (r_state == ST_IDLE);
    assign o_ex_ready   = (r_state == ST_IDLE);
    assign o_busy       = (r_state != ST_IDLE);
    assign o_csr_wr_set = 1'b0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_pc_q    <= '0;
            r_cause_q <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_pc_q    <= i_ex_pc;
                r_cause_q <= w_cause;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        o_csr_wr_en   = 1'b0;
        o_csr_wr_reg  = '0;
        o_csr_wr_bus  = '0;
        o_csr_rd_reg  = '0;
        o_redir_valid = 1'b0;
        o_redir_pc    = '0;
        case (r_state)
            ST_IDLE: begin
                if (i_ex_valid) begin
                    if (w_trap) begin
                        w_state_nxt = ST_W_EPC;
                    end else if (i_ex_mret) begin
                        w_state_nxt = ST_R_STAT;
                    end
                end
            end
            ST_W_EPC: begin
                o_csr_wr_en  = 1'b1;
                o_csr_wr_reg = CSR_MEPC;
                o_csr_wr_bus = r_pc_q & ~(XLEN'(3));
                w_state_nxt  = ST_W_CAUSE;
            end
            ST_W_CAUSE: begin
                o_csr_wr_en  = 1'b1;
                o_csr_wr_reg = CSR_MCAUSE;
                o_csr_wr_bus = XLEN'(r_cause_q);
                w_state_nxt  = ST_W_STAT;
            end
            ST_W_STAT: begin
                o_csr_rd_reg = CSR_MSTATUS;
                o_csr_wr_en  = 1'b1;
                o_csr_wr_reg = CSR_MSTATUS;
                o_csr_wr_bus = i_csr_rd_bus;
                o_csr_wr_bus[MSTATUS_MPIE] = i_csr_rd_bus[MSTATUS_MIE];
                o_csr_wr_bus[MSTATUS_MIE]  = 1'b0;
                o_csr_wr_bus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
                w_state_nxt  = ST_REDIR;
            end
            ST_REDIR: begin
                // Mode bits of mtvec are ignored: direct mode only.
                o_csr_rd_reg  = CSR_MTVEC;
                o_redir_valid = 1'b1;
                o_redir_pc    = i_csr_rd_bus & ~(XLEN'(3));
                if (i_redir_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_R_STAT: begin
                o_csr_rd_reg = CSR_MSTATUS;
                o_csr_wr_en  = 1'b1;
                o_csr_wr_reg = CSR_MSTATUS;
                o_csr_wr_bus = i_csr_rd_bus;
                o_csr_wr_bus[MSTATUS_MIE]  = i_csr_rd_bus[MSTATUS_MPIE];
                o_csr_wr_bus[MSTATUS_MPIE] = 1'b1;
                o_csr_wr_bus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
                w_state_nxt  = ST_REDIR_RET;
            end
            ST_REDIR_RET: begin
                o_csr_rd_reg  = CSR_MEPC;
                o_redir_valid = 1'b1;
                o_redir_pc    = i_csr_rd_bus;
                if (i_redir_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
